// File: rtl/amx_core_sched.sv
// amx_core_sched: round-robin burst scheduler sharing one amx_core1 between two requesters.
// Latency: a byte accepted in cycle t is presented on core_data_in at t+1; its response appears at t+CORE_LATENCY+2.
// Backpressure: req_ready is asserted only for the burst owner while in BURST; responses cannot be stalled.
//
// Optional feature macro: AMX_SCHED_WDOG_EN (owner-stall watchdog that aborts a stuck burst).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid[1:0]    per-requester byte valid
//   req_data0/1       requester bytes
//   req_last[1:0]     per-requester last-byte-of-burst flag
//   req_ready[1:0]    per-requester accept (combinational)
//   core_data_in      registered byte to amx_core1.data_in
//   core_data_out     result from amx_core1.data_out
//   rsp_valid/data/id response strobe, captured result, owning requester
//   busy              burst active, grant pending, or bytes still in flight
//   burst_cut         one-cycle pulse when a burst is pre-empted at MAX_BURST
//   abort             one-cycle pulse on watchdog abort (tied 0 without the macro)
module amx_core_sched #(
  parameter int unsigned CORE_LATENCY = 2,
  parameter int unsigned MAX_BURST    = 16,
  parameter logic [7:0]  IDLE_BYTE    = 8'h00,
  parameter int unsigned WDOG_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic [7:0] core_data_in,
  input  logic [7:0] core_data_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy,
  output logic       burst_cut,
  output logic       abort
);

  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic       owner;
  logic       last_grant;
  logic [7:0] burst_cnt;

  // Tracking pipe: one {valid,id} slot per cycle between accept and result capture.
  logic [CORE_LATENCY:0] pipe_vld;
  logic [CORE_LATENCY:0] pipe_id;

  logic       accept;
  logic       grant_vld;
  logic       grant_id;
  logic       cut_nxt;
  logic [7:0] cnt_inc;
  logic [7:0] own_data;
  logic       own_vld;
  logic       own_last;
  logic       oth_vld;

`ifdef AMX_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt;
  logic              abort_nxt;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    cut_nxt   = 1'b0;
`ifdef AMX_SCHED_WDOG_EN
    abort_nxt = 1'b0;
`endif
    own_vld  = req_valid[owner];
    oth_vld  = req_valid[~owner];
    own_last = req_last[owner];
    own_data = owner ? req_data1 : req_data0;
    // Saturating so a long uncontested burst never wraps back under the cap.
    cnt_inc  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;

    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          grant_vld = 1'b1;
          // On a tie the requester that did not win last time goes next.
          grant_id  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        req_ready = owner ? 2'b10 : 2'b01;
        accept    = own_vld;
        if (accept) begin
          if (own_last) begin
            state_nxt = S_IDLE;
          end else if ((cnt_inc >= MAX_BURST_B) && oth_vld) begin
            state_nxt = S_IDLE;
            cut_nxt   = 1'b1;
          end
        end
`ifdef AMX_SCHED_WDOG_EN
        else if (wdog_cnt == WDOG_LIM) begin
          state_nxt = S_IDLE;
          abort_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      burst_cnt    <= 8'd0;
      core_data_in <= IDLE_BYTE;
      pipe_vld     <= '0;
      pipe_id      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_id       <= 1'b0;
      burst_cut    <= 1'b0;
    end else begin
      if (grant_vld) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        burst_cnt  <= 8'd0;
      end else if (accept) begin
        burst_cnt  <= cnt_inc;
      end
      core_data_in <= accept ? own_data : IDLE_BYTE;
      pipe_vld     <= {pipe_vld[CORE_LATENCY-1:0], accept};
      pipe_id      <= {pipe_id[CORE_LATENCY-1:0], owner};
      // Tail slot lines up with the core result of the byte it tracks.
      rsp_valid    <= pipe_vld[CORE_LATENCY];
      rsp_id       <= pipe_id[CORE_LATENCY];
      rsp_data     <= core_data_out;
      burst_cut    <= cut_nxt;
    end
  end

`ifdef AMX_SCHED_WDOG_EN
  // Counts consecutive owner-idle cycles within a burst; restarts on each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= abort_nxt;
      if (grant_vld || (state == S_BURST && own_vld)) wdog_cnt <= '0;
      else if (state == S_BURST)                     wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // A pending grant counts as busy so upstream sees activity in the arbitration cycle.
  assign busy = (state == S_BURST) | (|pipe_vld) | ((state == S_IDLE) & (|req_valid));

endmodule

// File: tb/tb_amx_core_sched.sv
module tb_amx_core_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic [7:0] core_data_in;
  logic [7:0] core_data_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       busy;
  logic       burst_cut;
  logic       abort;

  int checks;
  int errors;
  int rsp_cnt;
  int cut_cnt;
  int abort_cnt;
  int acc;
  int snap;
  int abort_at;
  int grant_at;

  amx_core_sched #(
    .CORE_LATENCY(2),
    .MAX_BURST(16),
    .IDLE_BYTE(8'h00),
    .WDOG_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_last(req_last),
    .req_ready(req_ready),
    .core_data_in(core_data_in),
    .core_data_out(core_data_out),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy),
    .burst_cut(burst_cut),
    .abort(abort)
  );

  // Core stand-in: two-cycle latency, result = byte ^ 0x5A.
  logic [7:0] core_d1;
  logic [7:0] core_d2;
  always @(posedge clk) begin
    core_d1 <= core_data_in ^ 8'h5A;
    core_d2 <= core_d1;
  end
  assign core_data_out = core_d2;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt   <= rsp_cnt + 1;
    if (burst_cut) cut_cnt   <= cut_cnt + 1;
    if (abort)     abort_cnt <= abort_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_last  = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00; req_last = 2'b00;
    checks = 0; errors = 0; rsp_cnt = 0; cut_cnt = 0; abort_cnt = 0;
    abort_at = -1; grant_at = -1;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_core_data_in", {24'd0, core_data_in}, 32'h00);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_burst_cut", {31'd0, burst_cut}, 0);
    chk("rst_abort", {31'd0, abort}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req_ready", {30'd0, req_ready}, 0);

    // Single 3-byte burst from requester 0
    step(); rst = 1'b0;
    req_valid = 2'b01; req_data0 = 8'h11; req_last = 2'b00;           // C
    @(negedge clk); chk("t1_ready_idle", {30'd0, req_ready}, 2'b00);
    step();                                                            // C+1 accept 11
    @(negedge clk); chk("t1_ready_burst", {30'd0, req_ready}, 2'b01);
    chk("t1_busy", {31'd0, busy}, 1);
    step(); req_data0 = 8'h22;                                         // C+2
    @(negedge clk); chk("t1_core_11", {24'd0, core_data_in}, 8'h11);
    step(); req_data0 = 8'h33; req_last = 2'b01;                       // C+3
    @(negedge clk); chk("t1_core_22", {24'd0, core_data_in}, 8'h22);
    step(); req_valid = 2'b00; req_last = 2'b00;                       // C+4
    @(negedge clk); chk("t1_core_33", {24'd0, core_data_in}, 8'h33);
    chk("t1_back_idle", {30'd0, req_ready}, 2'b00);
    chk("t1_rsp_not_early", {31'd0, rsp_valid}, 0);
    step();                                                            // C+5
    @(negedge clk); chk("t1_rsp0_vld", {31'd0, rsp_valid}, 1);
    chk("t1_rsp0_id", {31'd0, rsp_id}, 0);
    chk("t1_rsp0_dat", {24'd0, rsp_data}, 8'h4B);
    chk("t1_core_idle", {24'd0, core_data_in}, 8'h00);
    step();                                                            // C+6
    @(negedge clk); chk("t1_rsp1_dat", {24'd0, rsp_data}, 8'h78);
    chk("t1_rsp1_vld", {31'd0, rsp_valid}, 1);
    step();                                                            // C+7
    @(negedge clk); chk("t1_rsp2_dat", {24'd0, rsp_data}, 8'h69);
    chk("t1_rsp2_id", {31'd0, rsp_id}, 0);
    step();                                                            // C+8
    @(negedge clk); chk("t1_rsp_done", {31'd0, rsp_valid}, 0);
    chk("t1_busy_done", {31'd0, busy}, 0);

    // Both requesters out of reset: alternation
    step(); do_reset();
    req_valid = 2'b11; req_data0 = 8'hA0; req_data1 = 8'hB0; req_last = 2'b00; // D
    @(negedge clk); chk("t2_ready_arb0", {30'd0, req_ready}, 2'b00);
    step();                                                            // D+1 accept A0
    @(negedge clk); chk("t2_grant_req0", {30'd0, req_ready}, 2'b01);
    step(); req_data0 = 8'hA1; req_last = 2'b01;                       // D+2
    @(negedge clk); chk("t2_core_a0", {24'd0, core_data_in}, 8'hA0);
    step(); req_valid = 2'b10; req_last = 2'b00;                       // D+3
    @(negedge clk); chk("t2_ready_arb1", {30'd0, req_ready}, 2'b00);
    chk("t2_core_a1", {24'd0, core_data_in}, 8'hA1);
    step();                                                            // D+4 accept B0
    @(negedge clk); chk("t2_grant_req1", {30'd0, req_ready}, 2'b10);
    step(); req_data1 = 8'hB1; req_last = 2'b10;                       // D+5
    step(); req_valid = 2'b11; req_data0 = 8'hC0; req_data1 = 8'hD0; req_last = 2'b00; // D+6
    @(negedge clk); chk("t2_ready_arb2", {30'd0, req_ready}, 2'b00);
    chk("t2_rsp_a1_id", {31'd0, rsp_id}, 0);
    chk("t2_rsp_a1_dat", {24'd0, rsp_data}, 8'hFB);
    step();                                                            // D+7
    @(negedge clk); chk("t2_alternate_req0", {30'd0, req_ready}, 2'b01);
    step(); req_valid = 2'b00;                                         // D+8
    @(negedge clk); chk("t2_rsp_b0_vld", {31'd0, rsp_valid}, 1);
    chk("t2_rsp_b0_id", {31'd0, rsp_id}, 1);
    chk("t2_rsp_b0_dat", {24'd0, rsp_data}, 8'hEA);

    // MAX_BURST pre-emption with requester 1 waiting
    step(); do_reset();
    snap = cut_cnt; acc = 0;
    req_valid = 2'b11; req_data0 = 8'h00; req_data1 = 8'hE0; req_last = 2'b00; // E
    step();                                                            // E+1
    for (int k = 0; k < 16; k++) begin
      req_data0 = 8'(k);
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) acc = acc + 1;
      step();
    end                                                                // E+17
    chk("t3_accepts", acc, 16);
    @(negedge clk); chk("t3_cut_pulse", {31'd0, burst_cut}, 1);
    chk("t3_ready_arb", {30'd0, req_ready}, 2'b00);
    chk("t3_core_last", {24'd0, core_data_in}, 8'h0F);
    step();                                                            // E+18
    @(negedge clk); chk("t3_grant_req1", {30'd0, req_ready}, 2'b10);
    chk("t3_cut_gone", {31'd0, burst_cut}, 0);
    step();
    chk("t3_cut_count", cut_cnt - snap, 1);

    // Cap reached with requester 1 idle: burst continues
    do_reset();
    snap = cut_cnt; acc = 0;
    req_valid = 2'b01; req_data0 = 8'h00; req_last = 2'b00;           // F
    step();                                                            // F+1
    for (int k = 0; k < 20; k++) begin
      req_data0 = 8'h40 + 8'(k);
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) acc = acc + 1;
      step();
    end                                                                // F+21
    chk("t4_accepts", acc, 20);
    @(negedge clk); chk("t4_core_last", {24'd0, core_data_in}, 8'h53);
    chk("t4_still_owner", {30'd0, req_ready}, 2'b01);
    step();
    chk("t4_no_cut", cut_cnt - snap, 0);

    // Owner stall with requester 1 waiting
    snap = abort_cnt;
    req_valid = 2'b10; req_data1 = 8'h77;                              // S
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (abort && abort_at < 0) abort_at = n;
      if (req_ready == 2'b10 && grant_at < 0) grant_at = n;
      step();
    end
`ifdef AMX_SCHED_WDOG_EN
    chk("t5_abort_cycle", abort_at, 32);
    chk("t5_grant_after_abort", grant_at, 33);
    chk("t5_abort_count", abort_cnt - snap, 1);
`else
    chk("t5_no_abort", abort_cnt - snap, 0);
    chk("t5_no_regrant", grant_at, -1);
    @(negedge clk); chk("t5_grant_held", {30'd0, req_ready}, 2'b01);
    step();
`endif

    // Reset with two bytes in flight
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h55; req_last = 2'b00;           // G
    step();                                                            // G+1 accept 55
    step(); req_data0 = 8'h66; req_last = 2'b01;                       // G+2 accept 66
    step(); req_valid = 2'b00; req_last = 2'b00; rst = 1'b1;           // G+3
    @(negedge clk); chk("t6_core_66", {24'd0, core_data_in}, 8'h66);
    step(); rst = 1'b0;                                                // G+4
    snap = rsp_cnt;
    @(negedge clk); chk("t6_core_idle", {24'd0, core_data_in}, 8'h00);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 0);
    for (int n = 0; n < 8; n++) step();
    chk("t6_no_rsp", rsp_cnt - snap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
